// File: rtl/uart_host_cmd_initiator.sv
// Host-side initiator for the UART-to-AXI4-Lite bridge: frames single-word read/write
// requests onto a TX byte stream and parses the bridge response. RX CRC check: HOST_CRC_CHECK_EN.
module uart_host_cmd_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
    parameter logic [7:0]  SOF_CMD        = 8'hA5,
    parameter logic [7:0]  SOF_RSP        = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rsp_valid,
    output logic [1:0]  rsp_error,
    output logic [7:0]  rsp_status,
    output logic [31:0] rsp_rdata,
    output logic        busy
);

    localparam int unsigned     TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_CRC     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_FRAME   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_SOF,
        S_TX_BODY,
        S_TX_CRC,
        S_RX_SOF,
        S_RX_BODY,
        S_RX_CRC,
        S_DONE
    } state_t;

    state_t            r_state, w_state_n;
    logic              r_read, w_read_n;
    logic [31:0]       r_addr, w_addr_n;
    logic [31:0]       r_wdata, w_wdata_n;
    logic [7:0]        r_cmd, w_cmd_n;
    logic [3:0]        r_idx, w_idx_n;
    logic [7:0]        r_crc, w_crc_n;
    logic [7:0]        r_tx_data, w_tx_data_n;
    logic              r_tx_valid, w_tx_valid_n;
    logic [TO_W-1:0]   r_to_cnt, w_to_cnt_n;
    logic [7:0]        r_status, w_status_n;
    logic              r_frame_err, w_frame_err_n;
    logic [31:0]       r_rdata_sh, w_rdata_sh_n;
    logic              r_rsp_valid, w_rsp_valid_n;
    logic [1:0]        r_rsp_error, w_rsp_error_n;
    logic [7:0]        r_rsp_status, w_rsp_status_n;
    logic [31:0]       r_rsp_rdata, w_rsp_rdata_n;

    logic              w_tx_hs;
    logic              w_in_rx;
    logic              w_crc_bad;
    logic [3:0]        w_body_last;
    logic [1:0]        w_end_err;

    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Body byte k of the command frame: CMD, ADDR LE, then WDATA LE.
    function automatic logic [7:0] body_byte(input logic [3:0] idx, input logic [7:0] cmd,
                                             input logic [31:0] addr, input logic [31:0] wdata);
        case (idx)
            4'd0:    return cmd;
            4'd1:    return addr[7:0];
            4'd2:    return addr[15:8];
            4'd3:    return addr[23:16];
            4'd4:    return addr[31:24];
            4'd5:    return wdata[7:0];
            4'd6:    return wdata[15:8];
            4'd7:    return wdata[23:16];
            4'd8:    return wdata[31:24];
            default: return '0;
        endcase
    endfunction

`ifdef HOST_CRC_CHECK_EN
    assign w_crc_bad = (rx_data != r_crc);
`else
    assign w_crc_bad = 1'b0;
`endif

    assign w_tx_hs     = r_tx_valid && tx_ready;
    assign w_in_rx     = (r_state == S_RX_SOF) || (r_state == S_RX_BODY) || (r_state == S_RX_CRC);
    assign w_body_last = r_read ? 4'd4 : 4'd8;
    assign w_end_err   = w_crc_bad ? ERR_CRC : (r_frame_err ? ERR_FRAME : ERR_OK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_read       <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cmd        <= '0;
            r_idx        <= '0;
            r_crc        <= '0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_to_cnt     <= '0;
            r_status     <= '0;
            r_frame_err  <= 1'b0;
            r_rdata_sh   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_error  <= '0;
            r_rsp_status <= '0;
            r_rsp_rdata  <= '0;
        end else begin
            r_state      <= w_state_n;
            r_read       <= w_read_n;
            r_addr       <= w_addr_n;
            r_wdata      <= w_wdata_n;
            r_cmd        <= w_cmd_n;
            r_idx        <= w_idx_n;
            r_crc        <= w_crc_n;
            r_tx_data    <= w_tx_data_n;
            r_tx_valid   <= w_tx_valid_n;
            r_to_cnt     <= w_to_cnt_n;
            r_status     <= w_status_n;
            r_frame_err  <= w_frame_err_n;
            r_rdata_sh   <= w_rdata_sh_n;
            r_rsp_valid  <= w_rsp_valid_n;
            r_rsp_error  <= w_rsp_error_n;
            r_rsp_status <= w_rsp_status_n;
            r_rsp_rdata  <= w_rsp_rdata_n;
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_read_n       = r_read;
        w_addr_n       = r_addr;
        w_wdata_n      = r_wdata;
        w_cmd_n        = r_cmd;
        w_idx_n        = r_idx;
        w_crc_n        = r_crc;
        w_tx_data_n    = r_tx_data;
        w_tx_valid_n   = r_tx_valid;
        w_to_cnt_n     = r_to_cnt;
        w_status_n     = r_status;
        w_frame_err_n  = r_frame_err;
        w_rdata_sh_n   = r_rdata_sh;
        w_rsp_valid_n  = 1'b0;
        w_rsp_error_n  = r_rsp_error;
        w_rsp_status_n = r_rsp_status;
        w_rsp_rdata_n  = r_rsp_rdata;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_read_n     = cmd_read;
                    w_addr_n     = cmd_addr;
                    w_wdata_n    = cmd_wdata;
                    w_cmd_n      = {cmd_read, 1'b0, 2'b10, 4'h0};
                    w_crc_n      = '0;
                    w_tx_data_n  = SOF_CMD;
                    w_tx_valid_n = 1'b1;
                    w_state_n    = S_TX_SOF;
                end
            end
            S_TX_SOF: begin
                if (w_tx_hs) begin
                    w_idx_n     = '0;
                    w_tx_data_n = r_cmd;
                    w_state_n   = S_TX_BODY;
                end
            end
            S_TX_BODY: begin
                // CRC folds in each body byte as it is handed off; the last one yields the CRC byte.
                if (w_tx_hs) begin
                    w_crc_n = crc8_upd(r_crc, r_tx_data);
                    if (r_idx == w_body_last) begin
                        w_tx_data_n = crc8_upd(r_crc, r_tx_data);
                        w_state_n   = S_TX_CRC;
                    end else begin
                        w_idx_n     = r_idx + 4'd1;
                        w_tx_data_n = body_byte(r_idx + 4'd1, r_cmd, r_addr, r_wdata);
                    end
                end
            end
            S_TX_CRC: begin
                if (w_tx_hs) begin
                    w_tx_valid_n  = 1'b0;
                    w_tx_data_n   = '0;
                    w_crc_n       = '0;
                    w_to_cnt_n    = '0;
                    w_status_n    = '0;
                    w_frame_err_n = 1'b0;
                    w_rdata_sh_n  = '0;
                    w_state_n     = S_RX_SOF;
                end
            end
            S_RX_SOF: begin
                if (rx_valid && (rx_data == SOF_RSP)) begin
                    w_idx_n   = '0;
                    w_state_n = S_RX_BODY;
                end
            end
            S_RX_BODY: begin
                if (rx_valid) begin
                    w_crc_n = crc8_upd(r_crc, rx_data);
                    if (r_idx == 4'd0) begin
                        w_status_n = rx_data;
                        w_idx_n    = 4'd1;
                    end else if (r_idx == 4'd1) begin
                        w_frame_err_n = (rx_data != r_cmd);
                        if (r_read && (r_status == 8'h00)) begin
                            w_idx_n = 4'd2;
                        end else begin
                            w_state_n = S_RX_CRC;
                        end
                    end else begin
                        w_rdata_sh_n = {rx_data, r_rdata_sh[31:8]};
                        if (r_idx == 4'd5) begin
                            w_state_n = S_RX_CRC;
                        end else begin
                            w_idx_n = r_idx + 4'd1;
                        end
                    end
                end
            end
            S_RX_CRC: begin
                if (rx_valid) begin
                    w_rsp_valid_n  = 1'b1;
                    w_rsp_error_n  = w_end_err;
                    w_rsp_status_n = r_status;
                    w_rsp_rdata_n  = ((w_end_err == ERR_OK) && r_read && (r_status == 8'h00))
                                     ? r_rdata_sh : '0;
                    w_state_n      = S_DONE;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // A byte arriving in the threshold cycle wins over the timeout.
        if (w_in_rx) begin
            if (rx_valid) begin
                w_to_cnt_n = '0;
            end else if (r_to_cnt == TO_LAST) begin
                w_rsp_valid_n  = 1'b1;
                w_rsp_error_n  = ERR_TIMEOUT;
                w_rsp_status_n = 8'hFF;
                w_rsp_rdata_n  = '0;
                w_state_n      = S_DONE;
            end else if (r_to_cnt != '1) begin
                w_to_cnt_n = r_to_cnt + TO_W'(1);
            end
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_error  = r_rsp_error;
    assign rsp_status = r_rsp_status;
    assign rsp_rdata  = r_rsp_rdata;

endmodule
